bcd_multi_counter: RTL and testbench
====================================

BCD_MULTI_COUNTER -- requirements
Module: bcd_multi_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of cascaded BCD digits (legal range 1..8).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_syn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port en, input, 1 bit: count enable.
REQ-005 Port up_dn, input, 1 bit: count direction; 1 = up, 0 = down.
REQ-006 Port load, input, 1 bit: parallel load request.
REQ-007 Port Din, input, 4*DIGITS bits: load value; digit k occupies bits [4k+3:4k], digit 0 is least significant.
REQ-008 Port Q, output, 4*DIGITS bits: registered BCD count, same digit packing as Din.
REQ-009 Port carry_out, output, 1 bit: registered one-cycle wrap pulse.
REQ-010 Port load_err, output, 1 bit: registered one-cycle pulse marking a rejected load.
REQ-011 Port Q_out, output, 8*DIGITS bits: active-low seven-segment-plus-dp code per digit; digit k occupies bits [8k+7:8k].

Function
REQ-012 Priority per clock edge SHALL be: load first, then en; with load=0 and en=0, Q SHALL hold.
REQ-013 Load with every Din digit <= 9 SHALL set Q = Din on the next edge, with carry_out=0 and load_err=0.
REQ-014 Load with any Din digit > 9 SHALL leave Q unchanged and set load_err=1 for exactly one cycle; en SHALL be ignored that cycle.
REQ-015 Up count (en=1, up_dn=1): digit 0 SHALL increment; a digit at 9 SHALL go to 0 and increment the next digit in the same edge (full ripple, single-cycle latency).
REQ-016 Down count (en=1, up_dn=0): digit 0 SHALL decrement; a digit at 0 SHALL go to 9 and decrement the next digit in the same edge.
REQ-017 Up wrap: all digits 9 -> all digits 0, with carry_out=1 for the cycle following that edge.
REQ-018 Down wrap: all digits 0 -> all digits 9, with carry_out=1 for the cycle following that edge.
REQ-019 carry_out and load_err SHALL be 0 in every cycle not covered by REQ-014, REQ-017 and REQ-018.
REQ-020 Q SHALL never hold a digit > 9 by any path.
REQ-021 Q_out SHALL be combinational from Q per digit: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex); any other code SHALL give FF (blank).
REQ-022 Toggling up_dn between consecutive enabled cycles SHALL take effect on the very next edge with no dead cycle.

Reset
REQ-023 rst_syn=0 SHALL immediately force Q=0, carry_out=0 and load_err=0, regardless of clk.
REQ-024 While rst_syn=0, Q_out SHALL show C0 on every digit (FF on blanked digits when REQ-026 applies).
REQ-025 Reset asserted mid-count or mid-load SHALL discard the operation; the first edge after release SHALL act on the inputs present at that edge.

Configuration
REQ-026 With macro BCD_LEADING_ZERO_BLANK_EN defined, every digit k >= 1 that is 0 and has all higher digits 0 SHALL output FF on Q_out; digit 0 SHALL always be displayed.
REQ-027 Without BCD_LEADING_ZERO_BLANK_EN, every digit SHALL display per REQ-021; Q, carry_out and load_err SHALL be identical in both builds.

Verification
REQ-028 DIGITS=4: reset, load Din=16'h0998, en=1, up_dn=1 for 3 cycles -> Q sequence 0999, 1000, 1001; carry_out stays 0.
REQ-029 Load 16'h9999, one up step -> Q=0000 and carry_out=1 for one cycle; the next up step -> Q=0001 and carry_out=0.
REQ-030 Load 16'h0000, one down step -> Q=9999 and carry_out=1 for one cycle; Q_out=90909090.
REQ-031 With Q=0042, load Din=16'h12A4 with en=1 -> Q stays 0042 and load_err=1 for one cycle only.
REQ-032 Assert rst_syn low between clk edges while Q=0357 -> Q=0000 immediately; after release, load plus en on the same edge -> load wins.
REQ-033 Q=0042 with BCD_LEADING_ZERO_BLANK_EN -> Q_out=FFFF99A4; without the macro -> Q_out=C0C099A4; Q=0000 with the macro -> FFFFFFC0.

Source files
------------

// File: rtl/bcd_multi_counter.sv
// Cascaded up/down BCD counter with validated parallel load and active-low 7-segment outputs.
// Optional leading-zero blanking of the display is enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bcd_multi_counter #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_syn,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   Din,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  carry_out,
    output logic                  load_err,
    output logic [8*DIGITS-1:0]   Q_out
);

    logic [4*DIGITS-1:0] q_q, q_d;
    logic                carry_q, carry_d;
    logic                err_q, err_d;
    logic [4*DIGITS-1:0] q_step;
    logic                step_wrap;
    logic                din_bad;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        unique case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Full ripple through all digits in one cycle; ripple out of the top digit is the wrap.
    always_comb begin : p_step
        logic       ripple;
        logic [3:0] dig;
        q_step = q_q;
        ripple = 1'b1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            dig = q_q[4*k +: 4];
            if (ripple) begin
                if (up_dn) begin
                    if (dig == 4'd9) begin
                        q_step[4*k +: 4] = 4'd0;
                    end else begin
                        q_step[4*k +: 4] = dig + 4'd1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        q_step[4*k +: 4] = 4'd9;
                    end else begin
                        q_step[4*k +: 4] = dig - 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
        end
        step_wrap = ripple;
    end

    always_comb begin
        din_bad = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (Din[4*k +: 4] > 4'd9) begin
                din_bad = 1'b1;
            end
        end
    end

    always_comb begin
        q_d     = q_q;
        carry_d = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            // A rejected load also swallows en for that cycle.
            if (din_bad) begin
                err_d = 1'b1;
            end else begin
                q_d = Din;
            end
        end else if (en) begin
            q_d     = q_step;
            carry_d = step_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            q_q     <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    // Scan from the most significant digit; blank zeros until the first non-zero digit.
    always_comb begin : p_seg
        logic       higher_zero;
        logic [3:0] dig;
        Q_out       = '1;
        higher_zero = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            dig = q_q[4*k +: 4];
            if (k >= 1 && higher_zero && dig == 4'd0) begin
                Q_out[8*k +: 8] = 8'hFF;
            end else begin
                Q_out[8*k +: 8] = seg7(dig);
            end
            higher_zero = higher_zero & (dig == 4'd0);
        end
    end
`else
    always_comb begin
        Q_out = '1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            Q_out[8*k +: 8] = seg7(q_q[4*k +: 4]);
        end
    end
`endif

    assign Q         = q_q;
    assign carry_out = carry_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_bcd_multi_counter.sv
// Directed self-checking bench for bcd_multi_counter (DIGITS=4); expectations follow the
// BCD_LEADING_ZERO_BLANK_EN build setting where the display differs.
module tb_bcd_multi_counter;

    logic        clk = 1'b0;
    logic        rst_syn;
    logic        en;
    logic        up_dn;
    logic        load;
    logic [15:0] Din;
    logic [15:0] Q;
    logic        carry_out;
    logic        load_err;
    logic [31:0] Q_out;

    int checks = 0;
    int errors = 0;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam logic [31:0] SegZero = 32'hFFFFFFC0;
    localparam logic [31:0] Seg0042 = 32'hFFFF99A4;
`else
    localparam logic [31:0] SegZero = 32'hC0C0C0C0;
    localparam logic [31:0] Seg0042 = 32'hC0C099A4;
`endif

    bcd_multi_counter #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst_syn   (rst_syn),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .Din       (Din),
        .Q         (Q),
        .carry_out (carry_out),
        .load_err  (load_err),
        .Q_out     (Q_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [15:0] q_exp, input logic c_exp,
                             input logic e_exp);
        chk({tag, ".Q"}, {16'h0, Q}, {16'h0, q_exp});
        chk({tag, ".carry"}, {31'h0, carry_out}, {31'h0, c_exp});
        chk({tag, ".err"}, {31'h0, load_err}, {31'h0, e_exp});
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_syn = 1'b0;
        en      = 1'b0;
        up_dn   = 1'b1;
        load    = 1'b0;
        Din     = 16'h0000;
        #2;
        chk_state("reset", 16'h0000, 1'b0, 1'b0);
        chk("reset.seg", Q_out, SegZero);
        tick();
        rst_syn = 1'b1;

        // Load then count up across a digit ripple
        load = 1'b1; Din = 16'h0998;
        tick();
        chk_state("ld0998", 16'h0998, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        tick(); chk_state("up1", 16'h0999, 1'b0, 1'b0);
        tick(); chk_state("up2", 16'h1000, 1'b0, 1'b0);
        tick(); chk_state("up3", 16'h1001, 1'b0, 1'b0);

        // Direction toggle takes effect immediately
        up_dn = 1'b0;
        tick(); chk_state("dn_tog", 16'h1000, 1'b0, 1'b0);
        tick(); chk_state("dn_rip", 16'h0999, 1'b0, 1'b0);
        up_dn = 1'b1;
        tick(); chk_state("up_tog", 16'h1000, 1'b0, 1'b0);

        en = 1'b0;
        tick(); chk_state("hold", 16'h1000, 1'b0, 1'b0);

        // Up wrap
        load = 1'b1; Din = 16'h9999;
        tick(); chk_state("ld9999", 16'h9999, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        tick(); chk_state("upwrap", 16'h0000, 1'b1, 1'b0);
        tick(); chk_state("upwrap_nx", 16'h0001, 1'b0, 1'b0);

        // Down wrap
        en = 1'b0; load = 1'b1; Din = 16'h0000;
        tick(); chk_state("ld0000", 16'h0000, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        tick(); chk_state("dnwrap", 16'h9999, 1'b1, 1'b0);
        chk("dnwrap.seg", Q_out, 32'h90909090);
        en = 1'b0;
        tick(); chk_state("dnwrap_nx", 16'h9999, 1'b0, 1'b0);

        // Rejected load ignores en
        load = 1'b1; Din = 16'h0042;
        tick(); chk_state("ld0042", 16'h0042, 1'b0, 1'b0);
        chk("seg0042", Q_out, Seg0042);
        Din = 16'h12A4; en = 1'b1; up_dn = 1'b1;
        tick(); chk_state("bad_ld", 16'h0042, 1'b0, 1'b1);
        load = 1'b0; en = 1'b0;
        tick(); chk_state("bad_ld_nx", 16'h0042, 1'b0, 1'b0);
        load = 1'b1; Din = 16'h000F;
        tick(); chk_state("bad_ld_lo", 16'h0042, 1'b0, 1'b1);

        // Decoder coverage of all valid codes
        Din = 16'h1234;
        tick(); chk("seg1234", Q_out, 32'hF9A4B099);
        Din = 16'h5678;
        tick(); chk("seg5678", Q_out, 32'h9282F880);

        // Asynchronous reset between edges, then load beats en
        Din = 16'h0357;
        tick(); chk_state("ld0357", 16'h0357, 1'b0, 1'b0);
        load = 1'b0;
        #2 rst_syn = 1'b0;
        #1 chk_state("async_rst", 16'h0000, 1'b0, 1'b0);
        chk("async_rst.seg", Q_out, SegZero);
        load = 1'b1; en = 1'b1; up_dn = 1'b1; Din = 16'h0005;
        tick(); chk_state("rst_held", 16'h0000, 1'b0, 1'b0);
        rst_syn = 1'b1;
        tick(); chk_state("ld_wins", 16'h0005, 1'b0, 1'b0);

        // Reset clears a pending carry pulse
        Din = 16'h9999;
        tick();
        load = 1'b0;
        tick(); chk_state("wrap2", 16'h0000, 1'b1, 1'b0);
        #2 rst_syn = 1'b0;
        #1 chk_state("rst_carry", 16'h0000, 1'b0, 1'b0);
        tick();
        rst_syn = 1'b1;
        tick(); chk_state("post_rst_up", 16'h0001, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
